// File: rtl/ysyx_22050243_mc_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_22050243_mc_ctrl
// Multi-cycle control unit for the NPC core. Decodes RV32I/RV64I + Zicsr
// opcodes into the control bundle and walks each instruction through
// IDLE -> DECODE -> EXEC -> (MEM) -> WB. ebreak, illegal opcodes and LSU
// timeouts park the unit in a sticky HALT state that only rst leaves.
//
// Ports
//   clk, rst            core clock, asynchronous active-high reset
//   inst_valid/ready    IFU handshake (ready only in IDLE), inst sampled on it
//   mem_req/mem_ack     LSU request held through MEM, single-cycle completion
//   alu_src .. csr_r    control bundle (reg_w only in WB, mem_r/mem_w only in MEM)
//   pc_we               one-cycle PC update strobe per retired instruction
//   halt, halt_cause    sticky stop flag; 01 ebreak, 10 illegal, 11 bus timeout
//   busy                unit is working on an instruction
// All outputs are registers loaded from the next-state view.
// ----------------------------------------------------------------------------
module ysyx_22050243_mc_ctrl #(
    parameter int XLEN        = 64,
    parameter int EN_CSR      = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [31:0] inst,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        alu_src,
    output logic [2:0]  mem2reg,
    output logic        reg_w,
    output logic        mem_r,
    output logic        mem_w,
    output logic        branch,
    output logic [1:0]  pc_src_ctrl,
    output logic [2:0]  alu_op,
    output logic        csr_r,
    output logic        pc_we,
    output logic        halt,
    output logic [1:0]  halt_cause,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic       alu_src;
        logic [2:0] mem2reg;
        logic       reg_w;
        logic       mem_r;
        logic       mem_w;
        logic       branch;
        logic [1:0] pc_src_ctrl;
        logic [2:0] alu_op;
        logic       csr_r;
    } bundle_t;

    localparam logic [6:0] OPC_NOP    = 7'b0000000;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_IMM32  = 7'b0011011;
    localparam logic [6:0] OPC_OP32   = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_r, state_next_s;
    logic [6:0]       op_r, op_next_s;
    logic [2:0]       f3_r, f3_next_s;
    bundle_t          bnd_r, bnd_next_s, dec_s;
    logic             dec_ebreak_s, dec_illegal_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic [1:0]       cause_next_s;
    logic             in_body_s;
    logic             unused_inst_s;

    // Only opcode and funct3 steer the control bundle.
    assign unused_inst_s = ^{inst[31:15], inst[11:7]};

    // Single-cycle decoder table applied to the latched opcode/funct3.
    always_comb begin
        dec_s         = '0;
        dec_ebreak_s  = 1'b0;
        dec_illegal_s = 1'b0;
        case (op_r)
            OPC_NOP, OPC_FENCE: begin
                dec_s = '0;
            end
            OPC_LUI:    begin dec_s.alu_src = 1'b1; dec_s.mem2reg = 3'b010; dec_s.reg_w = 1'b1; end
            OPC_AUIPC:  begin dec_s.alu_src = 1'b1; dec_s.mem2reg = 3'b100; dec_s.reg_w = 1'b1; end
            OPC_JAL:    begin dec_s.mem2reg = 3'b011; dec_s.reg_w = 1'b1; dec_s.pc_src_ctrl = 2'b01; end
            OPC_JALR: begin
                dec_s.alu_src     = 1'b1;
                dec_s.mem2reg     = 3'b011;
                dec_s.reg_w       = 1'b1;
                dec_s.pc_src_ctrl = 2'b10;
            end
            OPC_BRANCH: begin dec_s.branch = 1'b1; dec_s.alu_op = 3'b001; end
            OPC_LOAD: begin
                dec_s.alu_src = 1'b1;
                dec_s.mem2reg = 3'b001;
                dec_s.reg_w   = 1'b1;
                dec_s.mem_r   = 1'b1;
            end
            OPC_STORE:  begin dec_s.alu_src = 1'b1; dec_s.mem_w = 1'b1; end
            OPC_IMM:    begin dec_s.alu_src = 1'b1; dec_s.reg_w = 1'b1; dec_s.alu_op = 3'b011; end
            OPC_OP:     begin dec_s.reg_w = 1'b1; dec_s.alu_op = 3'b010; end
            OPC_IMM32: begin
                if (XLEN == 64) begin
                    dec_s.alu_src = 1'b1;
                    dec_s.reg_w   = 1'b1;
                    dec_s.alu_op  = 3'b111;
                end else begin
                    dec_illegal_s = 1'b1;
                end
            end
            OPC_OP32: begin
                if (XLEN == 64) begin
                    dec_s.reg_w  = 1'b1;
                    dec_s.alu_op = 3'b110;
                end else begin
                    dec_illegal_s = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                // funct3 000 covers ebreak/ecall: both stop the core.
                if (f3_r == 3'b000) begin
                    dec_ebreak_s = 1'b1;
                end else if (EN_CSR != 0) begin
                    dec_s.csr_r   = 1'b1;
                    dec_s.mem2reg = 3'b101;
                    dec_s.reg_w   = 1'b1;
                end else begin
                    dec_illegal_s = 1'b1;
                end
            end
            default: dec_illegal_s = 1'b1;
        endcase
    end

    // Next-state, latched-instruction, bundle, timeout-counter and cause logic.
    always_comb begin
        state_next_s = state_r;
        op_next_s    = op_r;
        f3_next_s    = f3_r;
        bnd_next_s   = bnd_r;
        cnt_next_s   = cnt_r;
        cause_next_s = halt_cause;
        case (state_r)
            S_IDLE: begin
                if (inst_valid && inst_ready) begin
                    op_next_s    = inst[6:0];
                    f3_next_s    = inst[14:12];
                    state_next_s = S_DECODE;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_DECODE: begin
                if (dec_ebreak_s) begin
                    cause_next_s = 2'b01;
                    state_next_s = S_HALT;
                end else if (dec_illegal_s) begin
                    cause_next_s = 2'b10;
                    state_next_s = S_HALT;
                end else begin
                    bnd_next_s   = dec_s;
                    state_next_s = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bnd_r.mem_r || bnd_r.mem_w) begin
                    state_next_s = S_MEM;
                end else begin
                    state_next_s = S_WB;
                end
            end
            S_MEM: begin
                // Ack is tested first so it wins over a same-cycle timeout.
                if (mem_ack) begin
                    cnt_next_s   = '0;
                    state_next_s = S_WB;
                end else if (cnt_r == CNT_LAST) begin
                    cnt_next_s   = '0;
                    cause_next_s = 2'b11;
                    state_next_s = S_HALT;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            S_WB: begin
                bnd_next_s   = '0;
                state_next_s = S_IDLE;
            end
            S_HALT: begin
                state_next_s = S_HALT;
            end
            default: begin
                bnd_next_s   = '0;
                state_next_s = S_IDLE;
            end
        endcase
    end

    assign in_body_s = (state_next_s == S_EXEC) || (state_next_s == S_MEM) || (state_next_s == S_WB);

    // State, context and output registers; rst clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            op_r        <= 7'd0;
            f3_r        <= 3'd0;
            bnd_r       <= '0;
            cnt_r       <= '0;
            inst_ready  <= 1'b1;
            mem_req     <= 1'b0;
            alu_src     <= 1'b0;
            mem2reg     <= 3'd0;
            reg_w       <= 1'b0;
            mem_r       <= 1'b0;
            mem_w       <= 1'b0;
            branch      <= 1'b0;
            pc_src_ctrl <= 2'd0;
            alu_op      <= 3'd0;
            csr_r       <= 1'b0;
            pc_we       <= 1'b0;
            halt        <= 1'b0;
            halt_cause  <= 2'd0;
            busy        <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            op_r        <= op_next_s;
            f3_r        <= f3_next_s;
            bnd_r       <= bnd_next_s;
            cnt_r       <= cnt_next_s;
            inst_ready  <= (state_next_s == S_IDLE);
            mem_req     <= (state_next_s == S_MEM);
            alu_src     <= in_body_s & bnd_next_s.alu_src;
            mem2reg     <= in_body_s ? bnd_next_s.mem2reg : 3'd0;
            reg_w       <= (state_next_s == S_WB) & bnd_next_s.reg_w;
            mem_r       <= (state_next_s == S_MEM) & bnd_next_s.mem_r;
            mem_w       <= (state_next_s == S_MEM) & bnd_next_s.mem_w;
            branch      <= in_body_s & bnd_next_s.branch;
            pc_src_ctrl <= in_body_s ? bnd_next_s.pc_src_ctrl : 2'd0;
            alu_op      <= in_body_s ? bnd_next_s.alu_op : 3'd0;
            csr_r       <= in_body_s & bnd_next_s.csr_r;
            pc_we       <= (state_next_s == S_WB);
            halt        <= (state_next_s == S_HALT);
            halt_cause  <= cause_next_s;
            busy        <= in_body_s || (state_next_s == S_DECODE);
        end
    end

endmodule

// File: tb/tb_ysyx_22050243_mc_ctrl.sv
module tb_ysyx_22050243_mc_ctrl;

    localparam int TO = 4;

    typedef struct packed {
        logic [1:0] cause;   // 0 retires, 1 ebreak halt, 2 illegal halt
        logic       alu_src;
        logic [2:0] mem2reg;
        logic       reg_w;
        logic       mem_r;
        logic       mem_w;
        logic       branch;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
        logic       csr_r;
    } bndl_t;

    typedef struct {
        logic [31:0] word;
        int          k;
        bndl_t       e;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        iv0 = 1'b0, ack0 = 1'b0, iv1 = 1'b0, ack1 = 1'b0;
    logic [31:0] inst0 = 32'd0, inst1 = 32'd0;
    logic        ir0, req0, als0, rw0, mr0, mw0, br0, csr0, pcwe0, hlt0, busy0;
    logic        ir1, req1, als1, rw1, mr1, mw1, br1, csr1, pcwe1, hlt1, busy1;
    logic [2:0]  m2r0, aop0, m2r1, aop1;
    logic [1:0]  pcs0, hc0, pcs1, hc1;
    logic [20:0] obs0, obs1;

    int n_vec = 0;
    int n_err = 0;

    assign obs0 = {ir0, req0, als0, m2r0, rw0, mr0, mw0, br0, pcs0, aop0, csr0, pcwe0, hlt0, hc0, busy0};
    assign obs1 = {ir1, req1, als1, m2r1, rw1, mr1, mw1, br1, pcs1, aop1, csr1, pcwe1, hlt1, hc1, busy1};

    ysyx_22050243_mc_ctrl #(.XLEN(64), .EN_CSR(1), .MEM_TIMEOUT(TO), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .inst_valid(iv0), .inst_ready(ir0), .inst(inst0),
        .mem_ack(ack0), .mem_req(req0), .alu_src(als0), .mem2reg(m2r0), .reg_w(rw0),
        .mem_r(mr0), .mem_w(mw0), .branch(br0), .pc_src_ctrl(pcs0), .alu_op(aop0),
        .csr_r(csr0), .pc_we(pcwe0), .halt(hlt0), .halt_cause(hc0), .busy(busy0)
    );

    ysyx_22050243_mc_ctrl #(.XLEN(32), .EN_CSR(0), .MEM_TIMEOUT(TO), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .inst_valid(iv1), .inst_ready(ir1), .inst(inst1),
        .mem_ack(ack1), .mem_req(req1), .alu_src(als1), .mem2reg(m2r1), .reg_w(rw1),
        .mem_r(mr1), .mem_w(mw1), .branch(br1), .pc_src_ctrl(pcs1), .alu_op(aop1),
        .csr_r(csr1), .pc_we(pcwe1), .halt(hlt1), .halt_cause(hc1), .busy(busy1)
    );

    function automatic bndl_t B(input logic [1:0] c, input logic als, input logic [2:0] m2r,
                                input logic rw, input logic mr, input logic mw, input logic br,
                                input logic [1:0] pcs, input logic [2:0] aop, input logic csr);
        B = '{cause: c, alu_src: als, mem2reg: m2r, reg_w: rw, mem_r: mr, mem_w: mw,
              branch: br, pc_src: pcs, alu_op: aop, csr_r: csr};
    endfunction

    // Reference decode straight from the opcode map of the ISA.
    function automatic bndl_t ref_bundle(input logic [31:0] w, input bit x64, input bit csr_en);
        logic [2:0] f3;
        f3 = w[14:12];
        case (w[6:0])
            7'h00, 7'h0F: ref_bundle = B(2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
            7'h37: ref_bundle = B(2'd0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
            7'h17: ref_bundle = B(2'd0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
            7'h6F: ref_bundle = B(2'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 1'b0);
            7'h67: ref_bundle = B(2'd0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 3'd0, 1'b0);
            7'h63: ref_bundle = B(2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0);
            7'h03: ref_bundle = B(2'd0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
            7'h23: ref_bundle = B(2'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0);
            7'h13: ref_bundle = B(2'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd3, 1'b0);
            7'h33: ref_bundle = B(2'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2, 1'b0);
            7'h1B: ref_bundle = x64 ? B(2'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd7, 1'b0)
                                    : B(2'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
            7'h3B: ref_bundle = x64 ? B(2'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd6, 1'b0)
                                    : B(2'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
            7'h73: begin
                if (f3 == 3'd0)  ref_bundle = B(2'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
                else if (csr_en) ref_bundle = B(2'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1);
                else             ref_bundle = B(2'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
            end
            default: ref_bundle = B(2'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input logic [20:0] got, input logic [20:0] exp, input int tag, input int n);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL outputs vec%0d cyc%0d: got %06h expected %06h", tag, n, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic [31:0] w, input logic a);
        if (d == 0) begin iv0 = v; inst0 = w; ack0 = a; end
        else begin iv1 = v; inst1 = w; ack1 = a; end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        #2;
        check(obs0, 21'h100000, 900, 0);
        check(obs1, 21'h100000, 901, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check(obs0, 21'h100000, 902, 0);
    endtask

    // Hand one instruction to DUT d and check every output on every cycle.
    // k: MEM cycle carrying mem_ack (k<1 or k>TO means the ack never comes in time).
    task automatic run_one(input int d, input int tag, input logic [31:0] w, input int k,
                           input bndl_t e, input bit rnd, output bit halted);
        bit          is_mem, tmo, a;
        int          n_mem, last;
        logic [20:0] exp, body;
        logic [31:0] r;
        is_mem = (e.cause == 2'd0) && (e.mem_r || e.mem_w);
        tmo    = is_mem && (k < 1 || k > TO);
        n_mem  = !is_mem ? 0 : (tmo ? TO : k);
        if (e.cause != 2'd0) last = 4;
        else if (tmo)        last = 5 + TO;
        else                 last = 4 + n_mem;
        halted = (e.cause != 2'd0) || tmo;
        body = '0;
        body[18] = e.alu_src; body[17:15] = e.mem2reg; body[11] = e.branch;
        body[10:9] = e.pc_src; body[8:6] = e.alu_op; body[5] = e.csr_r;
        r = $urandom;
        drive(d, 1'b1, w, rnd ? r[0] : 1'b0);
        tick;
        for (int n = 1; n <= last; n++) begin
            exp = '0;
            if (e.cause != 2'd0) begin
                if (n == 1) exp[0] = 1'b1;
                else begin exp[3] = 1'b1; exp[2:1] = e.cause; end
            end else if (tmo && n >= 3 + TO) begin
                exp[3] = 1'b1; exp[2:1] = 2'b11;
            end else if (n == 1) begin
                exp[0] = 1'b1;
            end else if (n <= 3 + n_mem) begin
                exp = body; exp[0] = 1'b1;
                if (n >= 3 && n <= 2 + n_mem) begin
                    exp[19] = 1'b1; exp[13] = e.mem_r; exp[12] = e.mem_w;
                end
                if (n == 3 + n_mem) begin exp[4] = 1'b1; exp[14] = e.reg_w; end
            end else begin
                exp[20] = 1'b1;
            end
            check(d == 0 ? obs0 : obs1, exp, tag, n);
            if (n < last) begin
                r = $urandom;
                if (n >= 3 && n <= 2 + n_mem) a = !tmo && (n == 2 + k);
                else                          a = rnd ? r[0] : 1'b0;
                drive(d, rnd ? r[1] : 1'b1, r, a);
                tick;
            end
        end
        drive(d, 1'b0, 32'd0, 1'b0);
    endtask

    vec_t        tbl[19];
    logic [6:0]  pool[13];
    bit          h;
    logic [31:0] w, r;
    int          sel, k;
    bndl_t       e;

    initial begin
        tbl[0]  = '{32'h00500093, 0, B(2'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd3, 1'b0)}; // addi
        tbl[1]  = '{32'h0000A103, 3, B(2'd0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0)}; // lw k=3
        tbl[2]  = '{32'h0020A023, 0, B(2'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0)}; // sw timeout
        tbl[3]  = '{32'h0020A023, 4, B(2'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0)}; // sw ack on 4th
        tbl[4]  = '{32'h0000A103, 1, B(2'd0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0)}; // lw k=1
        tbl[5]  = '{32'h00100073, 0, B(2'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0)}; // ebreak
        tbl[6]  = '{32'h0010009B, 0, B(2'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd7, 1'b0)}; // addiw
        tbl[7]  = '{32'h008000EF, 0, B(2'd0, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 1'b0)}; // jal
        tbl[8]  = '{32'h000080E7, 0, B(2'd0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 3'd0, 1'b0)}; // jalr
        tbl[9]  = '{32'h00208463, 0, B(2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd1, 1'b0)}; // beq
        tbl[10] = '{32'h002081B3, 0, B(2'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2, 1'b0)}; // add
        tbl[11] = '{32'h002081BB, 0, B(2'd0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd6, 1'b0)}; // addw
        tbl[12] = '{32'h123450B7, 0, B(2'd0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0)}; // lui
        tbl[13] = '{32'h00001097, 0, B(2'd0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0)}; // auipc
        tbl[14] = '{32'h300020F3, 0, B(2'd0, 1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1)}; // csrrs
        tbl[15] = '{32'h0000000F, 0, B(2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0)}; // fence
        tbl[16] = '{32'h00000000, 0, B(2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0)}; // nop
        tbl[17] = '{32'hFFFFFFFF, 0, B(2'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0)}; // illegal
        tbl[18] = '{32'h0000A103, 5, B(2'd0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0)}; // lw timeout
        pool = '{7'h00, 7'h0F, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1B, 7'h73};

        #2;
        do_reset;

        // Directed table on the 64-bit unit; stray ack in IDLE after each retire.
        for (int i = 0; i < 19; i++) begin
            run_one(0, i, tbl[i].word, tbl[i].k, tbl[i].e, 1'b0, h);
            if (h) begin
                do_reset;
            end else begin
                drive(0, 1'b0, 32'd0, 1'b1);
                tick;
                check(obs0, 21'h100000, 100 + i, 99);
                drive(0, 1'b0, 32'd0, 1'b0);
            end
        end

        // Reset pulse while in MEM: mem_req must fall without waiting for a clock.
        drive(0, 1'b1, 32'h0000A103, 1'b0);
        tick;
        drive(0, 1'b0, 32'd0, 1'b0);
        tick;
        tick;
        check(obs0, 21'h0CA001, 400, 3);
        #2;
        rst = 1'b1;
        #1;
        check(obs0, 21'h100000, 401, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_one(0, 402, tbl[0].word, 0, tbl[0].e, 1'b0, h);
        run_one(0, 403, tbl[7].word, 0, tbl[7].e, 1'b0, h);
        run_one(0, 404, tbl[8].word, 0, tbl[8].e, 1'b0, h);

        // 32-bit unit without CSRs.
        run_one(1, 300, 32'h0010009B, 0, B(2'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0), 1'b0, h);
        do_reset;
        run_one(1, 301, 32'h300020F3, 0, B(2'd2, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0), 1'b0, h);
        do_reset;
        run_one(1, 302, 32'h00500093, 0, B(2'd0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd3, 1'b0), 1'b0, h);
        run_one(1, 303, 32'h0000A103, 2, B(2'd0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0), 1'b0, h);
        run_one(1, 304, 32'h00100073, 0, B(2'd1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0), 1'b0, h);
        do_reset;

        // Random instructions, ack delays and stray inputs against the reference decode.
        for (int i = 0; i < 40; i++) begin
            r   = $urandom;
            sel = $urandom_range(0, 14);
            w   = r;
            if (sel < 13) w[6:0] = pool[sel];
            k = $urandom_range(1, TO + 2);
            e = ref_bundle(w, 1'b1, 1'b1);
            run_one(0, 200 + i, w, k, e, 1'b1, h);
            if (h) do_reset;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
